axis_bram_sched: RTL and testbench



---
 rtl/axis_bram_pkg.sv | 20 ++
 rtl/axis_bram_sched.sv | 142 ++++++++++++++
 tb/tb_axis_bram_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_bram_pkg.sv
// Definitions shared by axis_bram and its command scheduler.
// Holds the default index width, the scheduler state encoding and the job status rule.
package axis_bram_pkg;

    localparam int AXIS_BRAM_AW = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_START,
        ST_RD_RUN,
        ST_WR_RUN,
        ST_DONE
    } sched_state_t;

    // A job is clean only when tlast and the length limit land on the same beat.
    function automatic logic tlast_mismatch(input logic tlast, input logic hit_len);
        return tlast ^ hit_len;
    endfunction

endpackage

// File: rtl/axis_bram_sched.sv
// Single-job command scheduler for axis_bram: programs its control inputs, gates the
// upstream write stream, counts beats and reports each finished job with a status pulse.
module axis_bram_sched
    import axis_bram_pkg::*;
#(
    parameter int C_AXIS_BRAM_ADDR_WIDTH = AXIS_BRAM_AW
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] cmd_index,
    input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] cmd_length,
    output logic                              ctrl_axis_m_start,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_r_start_index,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_r_length,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_w_start_index,
    input  logic                              up_s_axis_tvalid,
    input  logic                              up_s_axis_tlast,
    output logic                              up_s_axis_tready,
    output logic                              s_axis_tvalid,
    input  logic                              s_axis_tready,
    input  logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              done,
    output logic                              done_write,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] done_beats,
    output logic                              done_err
);

    localparam int AW = C_AXIS_BRAM_ADDR_WIDTH;

    sched_state_t    state;
    logic            job_write;
    logic [AW-1:0]   job_len;
    logic [AW-1:0]   beat_cnt;
    logic [AW-1:0]   beat_cnt_inc;
    logic            beat;
    logic            beat_last;
    logic            beat_hit_len;
    logic            wr_gate;

    assign wr_gate          = (state == ST_WR_RUN);
    assign s_axis_tvalid    = wr_gate & up_s_axis_tvalid;
    assign up_s_axis_tready = wr_gate & s_axis_tready;
    assign busy             = (state != ST_IDLE);
    assign cmd_ready        = reset_n & (state == ST_IDLE);

    // Beat source follows the active job type; nothing counts outside the run states.
    always_comb begin
        beat      = 1'b0;
        beat_last = 1'b0;
        case (state)
            ST_RD_RUN: begin
                beat      = m_axis_tvalid & m_axis_tready;
                beat_last = m_axis_tlast;
            end
            ST_WR_RUN: begin
                beat      = up_s_axis_tvalid & s_axis_tready;
                beat_last = up_s_axis_tlast;
            end
            default: ;
        endcase
    end

    assign beat_cnt_inc = beat_cnt + AW'(1);
    assign beat_hit_len = (beat_cnt_inc == job_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            job_write          <= 1'b0;
            job_len            <= '0;
            beat_cnt           <= '0;
            ctrl_axis_m_start  <= 1'b0;
            ctrl_r_start_index <= '0;
            ctrl_r_length      <= '0;
            ctrl_w_start_index <= '0;
            done               <= 1'b0;
            done_write         <= 1'b0;
            done_beats         <= '0;
            done_err           <= 1'b0;
        end else begin
            ctrl_axis_m_start <= 1'b0;
            done              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        job_write <= cmd_write;
                        job_len   <= cmd_length;
                        beat_cnt  <= '0;
                        if (cmd_write) begin
                            ctrl_w_start_index <= cmd_index;
                        end else begin
                            ctrl_r_start_index <= cmd_index;
                            ctrl_r_length      <= cmd_length;
                        end
                        // Zero-length jobs of either type take one quiet cycle in RD_START
                        // with no start pulse and the write gate shut.
                        if (cmd_length == '0) begin
                            state <= ST_RD_START;
                        end else if (cmd_write) begin
                            state <= ST_WR_RUN;
                        end else begin
                            state             <= ST_RD_START;
                            ctrl_axis_m_start <= 1'b1;
                        end
                    end
                end
                ST_RD_START: begin
                    if (job_len == '0) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        done_write <= job_write;
                        done_beats <= '0;
                        done_err   <= 1'b0;
                    end else begin
                        state <= ST_RD_RUN;
                    end
                end
                ST_RD_RUN, ST_WR_RUN: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt_inc;
                        if (beat_last || beat_hit_len) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            done_write <= job_write;
                            done_beats <= beat_cnt_inc;
                            done_err   <= tlast_mismatch(beat_last, beat_hit_len);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_sched.sv
// Directed bench for axis_bram_sched: acts as host, upstream source and axis_bram taps.
module tb_axis_bram_sched;

    localparam int AW = 7;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_index;
    logic [AW-1:0] cmd_length;
    logic          ctrl_axis_m_start;
    logic [AW-1:0] ctrl_r_start_index;
    logic [AW-1:0] ctrl_r_length;
    logic [AW-1:0] ctrl_w_start_index;
    logic          up_s_axis_tvalid;
    logic          up_s_axis_tlast;
    logic          up_s_axis_tready;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic          done_write;
    logic [AW-1:0] done_beats;
    logic          done_err;

    int n_checks;
    int n_errors;
    int start_cnt;
    int done_cnt;
    int s_acc;

    axis_bram_sched #(.C_AXIS_BRAM_ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_index          (cmd_index),
        .cmd_length         (cmd_length),
        .ctrl_axis_m_start  (ctrl_axis_m_start),
        .ctrl_r_start_index (ctrl_r_start_index),
        .ctrl_r_length      (ctrl_r_length),
        .ctrl_w_start_index (ctrl_w_start_index),
        .up_s_axis_tvalid   (up_s_axis_tvalid),
        .up_s_axis_tlast    (up_s_axis_tlast),
        .up_s_axis_tready   (up_s_axis_tready),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .busy               (busy),
        .done               (done),
        .done_write         (done_write),
        .done_beats         (done_beats),
        .done_err           (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (ctrl_axis_m_start) start_cnt++;
        if (done) done_cnt++;
        if (s_axis_tvalid && s_axis_tready) s_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a command and return just after the edge that accepted it.
    task automatic issue(input bit wr, input int idx, input int len);
        bit accepted;
        accepted   = 1'b0;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_index  = idx[AW-1:0];
        cmd_length = len[AW-1:0];
        for (int k = 0; k < 20 && !accepted; k++) begin
            accepted = cmd_ready;
            cyc();
        end
        cmd_valid = 1'b0;
        if (!accepted) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr_beats(input int n, input int last_pos);
        for (int b = 1; b <= n; b++) begin
            up_s_axis_tvalid = 1'b1;
            up_s_axis_tlast  = (b == last_pos);
            chk("wr_gate_open", up_s_axis_tready, 1);
            cyc();
        end
        up_s_axis_tvalid = 1'b0;
        up_s_axis_tlast  = 1'b0;
    endtask

    task automatic rd_beats(input int n, input int last_pos);
        for (int b = 1; b <= n; b++) begin
            m_axis_tvalid = 1'b1;
            m_axis_tready = 1'b1;
            m_axis_tlast  = (b == last_pos);
            cyc();
        end
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
    endtask

    // Called in the cycle right after the final beat.
    task automatic check_done(input string tag, input bit wr, input int beats, input bit err);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_write"}, done_write, wr);
        chk({tag, "_beats"}, done_beats, beats);
        chk({tag, "_err"}, done_err, err);
        chk({tag, "_ready_in_done"}, cmd_ready, 0);
        cyc();
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_ready_after"}, cmd_ready, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int s0;
        int st0;
        int d0;
        n_checks = 0; n_errors = 0;
        start_cnt = 0; done_cnt = 0; s_acc = 0;
        reset_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_index = '0; cmd_length = '0;
        up_s_axis_tvalid = 0; up_s_axis_tlast = 0; s_axis_tready = 1;
        m_axis_tvalid = 0; m_axis_tready = 0; m_axis_tlast = 0;

        // Reset state
        #3;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", ctrl_axis_m_start, 0);
        chk("rst_gate", up_s_axis_tready, 0);
        chk("rst_ctrl", {ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index}, 0);
        cyc(); cyc();
        reset_n = 1'b1;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        cyc();

        // Write idx 4 len 4, tlast on beat 4
        s0 = s_acc;
        issue(1, 4, 4);
        chk("w1_busy", busy, 1);
        chk("w1_widx", ctrl_w_start_index, 4);
        wr_beats(4, 4);
        chk("w1_gate_closed", up_s_axis_tready, 0);
        check_done("w1", 1, 4, 0);
        chk("w1_s_beats", s_acc - s0, 4);

        // Read idx 4 len 4
        st0 = start_cnt;
        issue(0, 4, 4);
        chk("r1_start", ctrl_axis_m_start, 1);
        chk("r1_ridx", ctrl_r_start_index, 4);
        chk("r1_rlen", ctrl_r_length, 4);
        cyc();
        chk("r1_start_clr", ctrl_axis_m_start, 0);
        rd_beats(4, 4);
        check_done("r1", 0, 4, 0);
        chk("r1_start_cnt", start_cnt - st0, 1);

        // Write len 4 with early tlast on beat 2
        issue(1, 8, 4);
        wr_beats(2, 2);
        up_s_axis_tvalid = 1'b1;
        chk("w2_gate_closed", up_s_axis_tready, 0);
        check_done("w2", 1, 2, 1);
        chk("w2_gate_idle", up_s_axis_tready, 0);
        up_s_axis_tvalid = 1'b0;

        // Read then write back-to-back with cmd_valid held; upstream offers data throughout
        s0 = s_acc;
        up_s_axis_tvalid = 1'b1;
        cmd_valid = 1; cmd_write = 0; cmd_index = 7'd2; cmd_length = 7'd3;
        chk("bb_ready", cmd_ready, 1);
        cyc();
        cmd_write = 1; cmd_index = 7'd10; cmd_length = 7'd2;
        chk("bb_rd_gate", up_s_axis_tready, 0);
        cyc();
        rd_beats(3, 3);
        chk("bb_rd_done", done, 1);
        chk("bb_rd_beats", done_beats, 3);
        chk("bb_rd_err", done_err, 0);
        chk("bb_not_ready", cmd_ready, 0);
        chk("bb_no_leak", s_acc - s0, 0);
        cyc();
        chk("bb_ready2", cmd_ready, 1);
        cyc();
        cmd_valid = 0;
        chk("bb_wr_busy", busy, 1);
        chk("bb_widx", ctrl_w_start_index, 10);
        chk("bb_ridx_hold", ctrl_r_start_index, 2);
        wr_beats(2, 2);
        check_done("bb_wr", 1, 2, 0);

        // Read len 0
        st0 = start_cnt;
        issue(0, 6, 0);
        chk("z_start", ctrl_axis_m_start, 0);
        chk("z_done_early", done, 0);
        chk("z_busy", busy, 1);
        cyc();
        check_done("z", 0, 0, 0);
        chk("z_start_cnt", start_cnt - st0, 0);

        // Write len 0: gate never opens
        s0 = s_acc;
        up_s_axis_tvalid = 1'b1;
        issue(1, 3, 0);
        chk("zw_gate", up_s_axis_tready, 0);
        cyc();
        chk("zw_gate2", up_s_axis_tready, 0);
        check_done("zw", 1, 0, 0);
        chk("zw_no_beats", s_acc - s0, 0);
        up_s_axis_tvalid = 1'b0;

        // Reset during beat 2 of a write
        d0 = done_cnt;
        issue(1, 5, 4);
        wr_beats(1, 0);
        up_s_axis_tvalid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("ar_cmd_ready", cmd_ready, 0);
        chk("ar_busy", busy, 0);
        chk("ar_gate", up_s_axis_tready, 0);
        chk("ar_svalid", s_axis_tvalid, 0);
        chk("ar_widx", ctrl_w_start_index, 0);
        chk("ar_status", {done, done_write, done_beats, done_err}, 0);
        cyc(); cyc();
        up_s_axis_tvalid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("ar_ready_rel", cmd_ready, 1);
        chk("ar_no_done", done_cnt - d0, 0);
        cyc();
        issue(0, 1, 2);
        chk("ar_rd_start", ctrl_axis_m_start, 1);
        cyc();
        rd_beats(2, 2);
        check_done("ar_rd", 0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
